// File: rtl/blinker_nios2_proc_cpu_debug_cmd_sched.sv
// Debug command scheduler: queues captured JTAG debug commands and executes them one
// at a time as OCI memory accesses, break-register writes or trace-control writes.
module blinker_nios2_proc_cpu_debug_cmd_sched #(
   parameter int QDEPTH  = 4,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_ir,
   input  logic [37:0]       cmd_jdo,
   output logic              cmd_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              brk_wr,
   output logic [1:0]        brk_sel,
   output logic [31:0]       brk_data,
   output logic              trc_wr,
   output logic [15:0]       trc_data,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              overflow
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MEM  = 2'd2;

   logic [39:0]       queue_mem [QDEPTH];
   logic [39:0]       cmd_q;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       mon_q, mon_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              ovf_q, ovf_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              full, push, pop;
   logic [1:0]        ir_w;
   logic [37:0]       jdo_w;
   logic              jdo_unused;

   assign ir_w       = cmd_q[39:38];
   assign jdo_w      = cmd_q[37:0];
   assign jdo_unused = ^jdo_w[33:32];

   assign full      = (count_q == CNT_W'(QDEPTH));
   assign push      = cmd_valid && !full;
   assign cmd_ready = !full;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      mon_d   = mon_q;
      ready_d = ready_q;
      error_d = error_q;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            if (ir_w == 2'b01) begin
               ovf_d = 1'b0;
            end else if (ir_w == 2'b00) begin
               if (jdo_w[35:34] == 2'b01) begin
                  addr_d = jdo_w[ADDR_W-1:0];
               end else if (jdo_w[35] == 1'b1) begin
                  // op 10 is a write, op 11 a read
                  state_d = S_MEM;
                  we_d    = ~jdo_w[34];
                  wdata_d = jdo_w[31:0];
                  ready_d = 1'b0;
                  error_d = 1'b0;
                  tmo_d   = '0;
               end
            end
         end
         S_MEM: begin
            // an ack on the final timeout cycle still counts as a completion
            if (mem_ack) begin
               if (!we_q) begin
                  mon_d = mem_rdata;
               end
               addr_d  = addr_q + ADDR_W'(1);
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // a dropped push flags overflow even when a status command clears it this cycle
      if (cmd_valid && full) begin
         ovf_d = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         mon_q    <= '0;
         ready_q  <= 1'b1;
         error_q  <= 1'b0;
         ovf_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         mon_q    <= mon_d;
         ready_q  <= ready_d;
         error_q  <= error_d;
         ovf_q    <= ovf_d;
         tmo_q    <= tmo_d;
      end
   end

   // queue storage with a registered read port feeding the command register
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         queue_mem[wr_ptr_q] <= {cmd_ir, cmd_jdo};
      end
      if (pop) begin
         cmd_q <= queue_mem[rd_ptr_q];
      end
   end

   assign mem_req       = (state_q == S_MEM);
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign brk_wr        = (state_q == S_EXEC) && (ir_w == 2'b10);
   assign brk_sel       = jdo_w[37:36];
   assign brk_data      = jdo_w[31:0];
   assign trc_wr        = (state_q == S_EXEC) && (ir_w == 2'b11);
   assign trc_data      = jdo_w[15:0];
   assign MonDReg       = mon_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;
   assign overflow      = ovf_q;

endmodule

// File: doc/blinker_nios2_proc_cpu_debug_cmd_sched.md
BLINKER_NIOS2_PROC_CPU_DEBUG_CMD_SCHED -- requirements
Module: blinker_nios2_proc_cpu_debug_cmd_sched

Interface
REQ-001 Parameter QDEPTH, default 4, SHALL set the command queue depth in entries (power of 2, at least 2).
REQ-002 Parameter ADDR_W, default 8, SHALL set the OCI memory word-address width.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles a memory request waits for mem_ack.
REQ-004 clk  in  1: sole clock; all logic is on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 cmd_valid  in  1: one-cycle strobe of a captured debug command, already in the clk domain.
REQ-007 cmd_ir  in  2 / cmd_jdo  in  38: instruction and data of that command.
REQ-008 cmd_ready  out  1: high when the queue is not full.
REQ-009 mem_req  out  1 / mem_we  out  1 / mem_addr  out  ADDR_W / mem_wdata  out  32: OCI memory request.
REQ-010 mem_ack  in  1 / mem_rdata  in  32: memory completion and read data, valid in the ack cycle.
REQ-011 brk_wr  out  1 / brk_sel  out  2 / brk_data  out  32: break-register write pulse, register index and data.
REQ-012 trc_wr  out  1 / trc_data  out  16: trace-control write pulse and data.
REQ-013 MonDReg  out  32 / monitor_ready  out  1 / monitor_error  out  1 / overflow  out  1: read result and status.

Function
REQ-014 Push rule: cmd_valid with the queue full SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle. Otherwise the {cmd_ir, cmd_jdo} entry SHALL be written to the queue.
REQ-015 Simultaneous push and pop with the queue not full SHALL leave the count unchanged.
REQ-016 The queue SHALL be FIFO-ordered, and its pointers SHALL wrap modulo QDEPTH.
REQ-017 The FSM SHALL have the states IDLE, EXEC and MEM.
REQ-018 In IDLE with count>0, the FSM SHALL pop the head entry into a command register and go to EXEC on the next cycle.
REQ-019 cmd_ir=01 (status) in EXEC SHALL clear overflow and SHALL return to IDLE.
REQ-020 cmd_ir=10 (break) in EXEC SHALL pulse brk_wr for exactly one cycle, with brk_sel=jdo[37:36] and brk_data=jdo[31:0], then return to IDLE.
REQ-021 cmd_ir=11 (trace) in EXEC SHALL pulse trc_wr for exactly one cycle, with trc_data=jdo[15:0], then return to IDLE.
REQ-022 cmd_ir=00 (memory) SHALL decode op=jdo[35:34]:
- 00 = no-op, return to IDLE;
- 01 = load the address register with jdo[ADDR_W-1:0], return to IDLE;
- 10 = write, go to MEM with mem_we=1 and mem_wdata=jdo[31:0];
- 11 = read, go to MEM with mem_we=0.
REQ-023 On entering MEM, monitor_ready and monitor_error SHALL be cleared.
REQ-024 In MEM, mem_req SHALL be high and mem_addr/mem_we/mem_wdata SHALL be stable until mem_ack is sampled high.
REQ-025 Latency: a command pushed in cycle N with the queue empty and the FSM in IDLE SHALL cause EXEC (brk_wr, trc_wr or the EXEC state) in cycle N+2. For memory ops, mem_req SHALL assert in cycle N+3.
REQ-026 On the mem_ack cycle the block SHALL:
- register MonDReg<=mem_rdata if the op is a read;
- increment the address register modulo 2^ADDR_W, so all-ones wraps to 0;
- set monitor_ready in the next cycle;
- return to IDLE.
REQ-027 The timeout counter SHALL clear on entering MEM. If it reaches TIMEOUT without mem_ack, the block SHALL:
- drop mem_req;
- set monitor_error=1 and monitor_ready=1;
- leave the address register and MonDReg unchanged;
- return to IDLE.
REQ-028 mem_ack arriving on the timeout cycle SHALL take precedence as a normal completion.
REQ-029 mem_ack outside MEM SHALL be ignored.
REQ-030 brk_wr, trc_wr and mem_req SHALL never be high in the same cycle.

Reset
REQ-031 Reset SHALL force, in the same cycle:
- the FSM to IDLE;
- the queue to empty and the address register to 0;
- MonDReg to 0;
- monitor_ready=1, monitor_error=0 and overflow=0;
- mem_req, brk_wr and trc_wr to 0.
REQ-032 Reset asserted mid-MEM SHALL drop mem_req in the next cycle and discard all queued commands.
REQ-033 cmd_valid asserted during reset SHALL be ignored.

Verification
REQ-034 Sequence: load address 0x10, then read, with mem_ack 3 cycles after mem_req and rdata 0xDEADBEEF -> mem_addr=0x10, MonDReg=0xDEADBEEF, monitor_ready rises, address becomes 0x11.
REQ-035 Load address 0xFF, then write 0x12345678 -> mem_we=1 at address 0xFF, and the address register wraps to 0x00.
REQ-036 Break command with jdo[37:36]=2 and data 0xA5A5A5A5 pushed at cycle N -> a single brk_wr pulse at N+2 with brk_sel=2.
REQ-037 QDEPTH+1 back-to-back pushes while a read stalls -> the final push is dropped, overflow=1, and the queued commands execute in order. A subsequent status command clears overflow.
REQ-038 Read with mem_ack never asserted -> mem_req deasserts after 255 cycles, and monitor_error=1 with monitor_ready=1.
REQ-039 Reset pulsed while mem_req is high with 2 commands queued -> mem_req=0, the queue is empty, and no brk_wr or trc_wr fires afterward.
